// File: rtl/mmul_c_pkg.sv
// Shared encodings and sizes for the Montgomery-multiplier C register sequencer.
package mmul_c_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned NWORDS = 16;
  localparam int unsigned CNT_W  = 9;

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_LOAD = 2'b01,
    OP_SHL  = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StShl,
    StRead,
    StDone
  } state_e;

endpackage

// File: rtl/mmul_c_seq_cnt.sv
// Loadable down-counter for SHL; the load value saturates at MAX_VAL and is_one flags the
// final shift cycle.
module mmul_c_seq_cnt #(
  parameter int unsigned CNT_W   = 9,
  parameter int unsigned MAX_VAL = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val > MaxCnt) ? MaxCnt : load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - OneCnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one = (cnt_q == OneCnt);

endmodule

// File: rtl/mmul_c_reg_seq.sv
// Command sequencer for the 257-bit C register: turns CLR/LOAD/SHL/READ commands into
// per-cycle register strobes behind valid/ready streams.
module mmul_c_reg_seq #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned NWORDS = 16,
  parameter int unsigned CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              carry,
  output logic [WORD_W-1:0] reg_din,
  output logic              reg_we,
  output logic              reg_sel_cyc,
  output logic              reg_sel_ls,
  output logic              reg_clr,
  input  logic [WORD_W-1:0] reg_dout,
  input  logic              reg_b256
);

  import mmul_c_pkg::*;

  localparam int unsigned WCNT_W = $clog2(NWORDS);
  localparam logic [WCNT_W-1:0] WcntLast = WCNT_W'(NWORDS - 1);
  localparam logic [WCNT_W-1:0] WcntOne  = WCNT_W'(1);

  state_e            state_d, state_q;
  logic [WCNT_W-1:0] wcnt_d, wcnt_q;
  logic              carry_q;
  logic              cmd_hs;
  logic              shl_is_one;

  assign cmd_hs = (state_q == StIdle) && cmd_valid;

  // Loaded on every accepted command; only SHL looks at it.
  mmul_c_seq_cnt #(
    .CNT_W   (CNT_W),
    .MAX_VAL (WORD_W * NWORDS)
  ) u_shl_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cmd_hs),
    .load_val (cmd_cnt),
    .dec      (state_q == StShl),
    .is_one   (shl_is_one)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          wcnt_d = '0;
          unique case (op_e'(cmd_op))
            OP_CLR:  state_d = StClr;
            OP_LOAD: state_d = StLoad;
            OP_SHL:  state_d = (cmd_cnt == '0) ? StDone : StShl;
            OP_READ: state_d = StRead;
          endcase
        end
      end
      StClr: state_d = StDone;
      StLoad: begin
        if (in_valid) begin
          wcnt_d = wcnt_q + WcntOne;
          if (wcnt_q == WcntLast) state_d = StDone;
        end
      end
      StShl: begin
        if (shl_is_one) state_d = StDone;
      end
      StRead: begin
        if (out_ready) begin
          wcnt_d = wcnt_q + WcntOne;
          if (wcnt_q == WcntLast) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == StDone) carry_q <= reg_b256;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    cmd_ready   = (state_q == StIdle);
    in_ready    = (state_q == StLoad);
    out_valid   = (state_q == StRead);
    done        = (state_q == StDone);
    reg_din     = in_ready ? in_data : '0;
    reg_clr     = (state_q == StClr);
    reg_sel_ls  = (state_q == StShl);
    reg_sel_cyc = out_valid && out_ready;
    reg_we      = (in_ready && in_valid) || reg_sel_ls || reg_sel_cyc;
  end

  assign out_data = reg_dout;
  assign carry    = carry_q;

endmodule

// File: tb/tb_mmul_c_reg_seq.sv
// Randomised bench for mmul_c_reg_seq with a behavioural C register and a 257-bit value model.
module tb_mmul_c_reg_seq;

  import mmul_c_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [8:0]  cmd_cnt = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        done;
  logic        carry;
  logic [15:0] reg_din;
  logic        reg_we, reg_sel_cyc, reg_sel_ls, reg_clr;
  logic [15:0] reg_dout;
  logic        reg_b256;

  always #5 clk = ~clk;

  mmul_c_reg_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_cnt     (cmd_cnt),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .done        (done),
    .carry       (carry),
    .reg_din     (reg_din),
    .reg_we      (reg_we),
    .reg_sel_cyc (reg_sel_cyc),
    .reg_sel_ls  (reg_sel_ls),
    .reg_clr     (reg_clr),
    .reg_dout    (reg_dout),
    .reg_b256    (reg_b256)
  );

  // Behavioural C register; it has no reset of its own.
  logic [256:0] creg = '0;
  assign reg_dout = creg[15:0];
  assign reg_b256 = creg[256];

  always @(posedge clk) begin
    if (reg_clr) creg <= '0;
    else if (reg_we) begin
      if (reg_sel_ls)       creg <= creg << 1;
      else if (reg_sel_cyc) creg <= {creg[256], creg[15:0], creg[255:16]};
      else                  creg <= {creg[256], reg_din, creg[255:16]};
    end
  end

  int n_we = 0, n_clr = 0, n_ls = 0, n_cyc = 0, n_bad = 0, n_stall_wr = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      n_we  <= n_we + int'(reg_we);
      n_clr <= n_clr + int'(reg_clr);
      n_ls  <= n_ls + int'(reg_sel_ls);
      n_cyc <= n_cyc + int'(reg_sel_cyc);
      if ((int'(reg_clr) + int'(reg_sel_ls) + int'(reg_sel_cyc)) > 1) n_bad <= n_bad + 1;
      else if (cmd_ready && (reg_we || reg_clr)) n_bad <= n_bad + 1;
      if ((reg_we && in_ready && !in_valid) || (reg_we && out_valid && !out_ready))
        n_stall_wr <= n_stall_wr + 1;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [256:0] model_v = '0;
  logic [15:0]  ld_words [16];
  logic [15:0]  rd_q [$];

  // mode 0: never stall, 1: stall every third cycle, 2: random stalls.
  function automatic logic flow(input int mode, input int lat);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (lat % 3) != 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_cmd(input logic [1:0] op, input int cnt, input int mode, output int lat);
    int wi;
    bit ok;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = 9'(cnt);
    #1;
    check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
    rd_q.delete();
    wi  = 0;
    lat = 0;
    ok  = 1'b0;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
      in_valid  = flow(mode, lat);
      in_data   = ld_words[wi % 16];
      out_ready = flow(mode, lat);
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (in_valid && in_ready) wi++;
      if (out_valid && out_ready) rd_q.push_back(out_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!ok) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic clr_cmd();
    int lat, b_clr;
    b_clr = n_clr;
    do_cmd(OP_CLR, 0, 0, lat);
    model_v = '0;
    check("clr_latency", 32'(lat), 32'd2);
    check("clr_pulses", 32'(n_clr - b_clr), 32'd1);
    check("clr_carry", 32'(carry), 32'(model_v[256]));
  endtask

  task automatic load_cmd(input int mode);
    int lat, b_we;
    b_we = n_we;
    do_cmd(OP_LOAD, 0, mode, lat);
    for (int i = 0; i < 16; i++) model_v[16*i +: 16] = ld_words[i];
    if (mode == 0) check("load_latency", 32'(lat), 32'd17);
    check("load_we_pulses", 32'(n_we - b_we), 32'd16);
    check("load_carry", 32'(carry), 32'(model_v[256]));
  endtask

  task automatic shl_cmd(input int n);
    int lat, b_ls, b_we, exp_n;
    exp_n = (n > 256) ? 256 : n;
    b_ls  = n_ls;
    b_we  = n_we;
    do_cmd(OP_SHL, n, 0, lat);
    model_v = model_v << exp_n;
    check("shl_latency", 32'(lat), 32'(exp_n + 1));
    check("shl_ls_pulses", 32'(n_ls - b_ls), 32'(exp_n));
    check("shl_we_pulses", 32'(n_we - b_we), 32'(exp_n));
    check("shl_carry", 32'(carry), 32'(model_v[256]));
  endtask

  task automatic read_cmd(input int mode);
    int lat, b_cyc;
    logic [15:0] got;
    b_cyc = n_cyc;
    do_cmd(OP_READ, 0, mode, lat);
    if (mode == 0) check("read_latency", 32'(lat), 32'd17);
    check("read_count", 32'(rd_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      got = (i < rd_q.size()) ? rd_q[i] : 16'hxxxx;
      check($sformatf("read_word%0d", i), 32'(got), 32'(model_v[16*i +: 16]));
    end
    check("read_cyc_pulses", 32'(n_cyc - b_cyc), 32'd16);
    check("read_carry", 32'(carry), 32'(model_v[256]));
  endtask

  task automatic rand_words(input bit set255);
    for (int i = 0; i < 16; i++) ld_words[i] = 16'($urandom);
    if (set255) ld_words[15][15] = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_strobes", {26'd0, in_ready, out_valid, reg_we, reg_clr, reg_sel_cyc, reg_sel_ls},
          32'd0);
    check("rst_done_carry", {30'd0, done, carry}, 32'd0);
    check("rst_reg_din", 32'(reg_din), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    clr_cmd();

    for (int i = 0; i < 16; i++) ld_words[i] = 16'(i);
    load_cmd(1);
    read_cmd(2);
    read_cmd(0);

    rand_words(1'b1);
    load_cmd(0);
    shl_cmd(1);
    check("shl1_carry_set", 32'(carry), 32'd1);
    shl_cmd(0);

    for (int it = 0; it < 6; it++) begin
      rand_words(1'(it[0]));
      load_cmd(it % 3);
      shl_cmd(int'($urandom_range(0, 40)));
      read_cmd(it % 3);
    end

    rand_words(1'b1);
    load_cmd(0);
    shl_cmd(300);
    read_cmd(0);

    // Reset while the 8th LOAD word is on the bus.
    rand_words(1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      in_valid  = 1'b1;
      in_data   = ld_words[i];
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_we", 32'(reg_we), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    rand_words(1'b0);
    load_cmd(0);
    read_cmd(0);

    // cmd_valid held high with CLR: one IDLE cycle between commands.
    begin
      int b_clr;
      b_clr = n_clr;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLR;
        #1;
        check($sformatf("b2b_ready%0d", k), 32'(cmd_ready), 32'((k % 3) == 0));
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("b2b_clr_pulses", 32'(n_clr - b_clr), 32'd4);
      model_v = '0;
    end
    read_cmd(0);

    check("strobe_exclusive", 32'(n_bad), 32'd0);
    check("no_stall_writes", 32'(n_stall_wr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
